// File: rtl/min_max_pkg.sv
// Shared definitions for the min/max LED bar: command encodings, value/LED types, thermometer helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package min_max_pkg;

    // Mode command encodings.
    localparam logic [1:0] COM_NORMAL = 2'b00;
    localparam logic [1:0] COM_LINEAR = 2'b01;
    localparam logic [1:0] COM_OFF    = 2'b10;
    localparam logic [1:0] COM_ON     = 2'b11;

    // Default build width.
    // Modules parameterised to other widths size their own vectors from VALSIZE.
    localparam int VALSIZE_DEF = 4;
    localparam int NLEDS_DEF   = 1 << VALSIZE_DEF;

    typedef logic [VALSIZE_DEF-1:0] value_t;
    typedef logic [NLEDS_DEF-1:0]   leds_t;

    // Bits 0..value set, all higher bits clear.
    function automatic leds_t thermometer(input value_t value);
        leds_t t;
        for (int i = 0; i < NLEDS_DEF; i++) begin
            t[i] = (i <= int'(value));
        end
        return t;
    endfunction

endpackage

// File: rtl/min_max_decode.sv
// Combinational LED pattern for one set of inputs (window + osc tail, linear bar, all off, all on).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
// Ports: com_i mode, min_i/max_i window, val_i value, osc_i tail blink level, leds_o pattern.
module min_max_decode
    import min_max_pkg::*;
#(
    parameter int VALSIZE = VALSIZE_DEF
) (
    input  logic [1:0]              com_i,
    input  logic [VALSIZE-1:0]      min_i,
    input  logic [VALSIZE-1:0]      max_i,
    input  logic [VALSIZE-1:0]      val_i,
    input  logic                    osc_i,
    output logic [(1<<VALSIZE)-1:0] leds_o
);

    localparam int NLEDS = 1 << VALSIZE;

    // Same rule as the package thermometer, sized to this instance's width.
    function automatic logic [NLEDS-1:0] therm(input logic [VALSIZE-1:0] v);
        logic [NLEDS-1:0] t;
        for (int i = 0; i < NLEDS; i++) begin
            t[i] = (i <= int'(v));
        end
        return t;
    endfunction

    logic [NLEDS-1:0] therm_val;
    logic [NLEDS-1:0] therm_max;
    logic [NLEDS-1:0] below_min;
    logic [NLEDS-1:0] on_mask;
    logic [NLEDS-1:0] tail_mask;
    logic             in_window;

    always_comb begin
        therm_val = therm(val_i);
        therm_max = therm(max_i);
        // LEDs strictly below min.
        // min = 0 has no such LEDs, so that case is forced to zero.
        // Otherwise therm(min-1) would wrap to all ones.
        below_min = (min_i == '0) ? '0 : therm(min_i - VALSIZE'(1));
        on_mask   = therm_val & ~below_min;
        tail_mask = therm_max & ~therm_val;
        // An empty window (min > max) can never contain val, so it falls out as all-off.
        in_window = (min_i <= val_i) && (val_i <= max_i);

        leds_o = '0;
        case (com_i)
            COM_NORMAL: leds_o = in_window ? (on_mask | (osc_i ? tail_mask : '0)) : '0;
            COM_LINEAR: leds_o = therm_val;
            COM_OFF:    leds_o = '0;
            COM_ON:     leds_o = '1;
            default:    leds_o = '0;
        endcase
    end

endmodule

// File: rtl/min_max_leds.sv
// LED bar driver: registers the decoded min/max/value pattern onto the board LEDs.
// Latency: 1 cycle (inputs at edge k appear on leds_o right after edge k).
// Backpressure: none; inputs sampled every cycle.
// Ports: clk_i, rst_ni (sync, active low), com_i, max_i, min_i, osc_i, val_i in; leds_o out.
module min_max_leds
    import min_max_pkg::*;
#(
    parameter int VALSIZE = VALSIZE_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [1:0]              com_i,
    input  logic [VALSIZE-1:0]      max_i,
    input  logic [VALSIZE-1:0]      min_i,
    input  logic                    osc_i,
    input  logic [VALSIZE-1:0]      val_i,
    output logic [(1<<VALSIZE)-1:0] leds_o
);

    localparam int NLEDS = 1 << VALSIZE;

    logic [NLEDS-1:0] leds_d;
    logic [NLEDS-1:0] leds_q;

    min_max_decode #(
        .VALSIZE (VALSIZE)
    ) u_decode (
        .com_i  (com_i),
        .min_i  (min_i),
        .max_i  (max_i),
        .val_i  (val_i),
        .osc_i  (osc_i),
        .leds_o (leds_d)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            leds_q <= '0;
        end else begin
            leds_q <= leds_d;
        end
    end

    assign leds_o = leds_q;

endmodule

// File: tb/tb_min_max_leds.sv
// Bench for min_max_leds: directed steps followed by randomized cycles against a per-LED rule model.
// Latency: checks leds_o 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_min_max_leds;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  com;
    logic [3:0]  min_v, max_v, val_v;
    logic        osc;
    logic [15:0] leds;

    int checks   = 0;
    int failures = 0;

    min_max_leds #(.VALSIZE(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .com_i  (com),
        .max_i  (max_v),
        .min_i  (min_v),
        .osc_i  (osc),
        .val_i  (val_v),
        .leds_o (leds)
    );

    always #5 clk = ~clk;

    // Reference: each LED decided independently from the mode rules.
    function automatic logic [15:0] model(input logic r, input logic [1:0] c,
                                          input int mn, input int mx, input int v,
                                          input logic o);
        logic [15:0] e;
        e = 16'h0000;
        if (!r) return e;
        for (int i = 0; i < 16; i++) begin
            case (c)
                2'b00: begin
                    if (mn <= v && v <= mx) begin
                        if (i >= mn && i <= v)      e[i] = 1'b1;
                        else if (i > v && i <= mx)  e[i] = o;
                    end
                end
                2'b01: e[i] = (i <= v);
                2'b10: e[i] = 1'b0;
                default: e[i] = 1'b1;
            endcase
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        checks++;
        assert (leds === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, leds, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] c, input int mn,
                         input int mx, input int v, input logic o);
        rst_n = r;
        com   = c;
        min_v = 4'(mn);
        max_v = 4'(mx);
        val_v = 4'(v);
        osc   = o;
    endtask

    // Apply inputs, clock one edge, and sample just after it.
    task automatic step(input logic r, input logic [1:0] c, input int mn,
                        input int mx, input int v, input logic o);
        drive(r, c, mn, mx, v, o);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        r_o;
        logic [1:0]  c_o;
        int          mn, mx, v;
        logic        o_o;
        logic        o_t;

        drive(1'b0, 2'b11, 0, 0, 0, 1'b0);
        #1;

        // Reset holds LEDs off even with all-on requested.
        step(1'b0, 2'b11, 0, 0, 0, 1'b0);
        check("reset_edge1", 16'h0000);
        step(1'b0, 2'b11, 0, 0, 0, 1'b0);
        check("reset_edge2", 16'h0000);
        step(1'b1, 2'b11, 0, 0, 0, 1'b0);
        check("reset_release_on", 16'hFFFF);

        // Normal window with tail.
        step(1'b1, 2'b00, 3, 12, 8, 1'b1);
        check("normal_osc1", 16'h1FF8);
        step(1'b1, 2'b00, 3, 12, 8, 1'b0);
        check("normal_osc0", 16'h01F8);
        o_t = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 2'b00, 3, 12, 8, o_t);
            check("normal_osc_toggle", o_t ? 16'h1FF8 : 16'h01F8);
            o_t = ~o_t;
        end

        // Window boundaries.
        step(1'b1, 2'b00, 3, 12, 13, 1'b1);
        check("val_above_max", 16'h0000);
        step(1'b1, 2'b00, 3, 12, 2, 1'b1);
        check("val_below_min", 16'h0000);
        step(1'b1, 2'b00, 0, 0, 0, 1'b1);
        check("all_zero_window", 16'h0001);
        step(1'b1, 2'b00, 10, 5, 7, 1'b1);
        check("min_gt_max", 16'h0000);
        step(1'b1, 2'b00, 0, 15, 15, 1'b0);
        check("full_window", 16'hFFFF);
        step(1'b1, 2'b00, 6, 6, 6, 1'b1);
        check("single_led_window", 16'h0040);

        // Linear bar.
        step(1'b1, 2'b01, 9, 12, 5, 1'b1);
        check("linear_5", 16'h003F);
        step(1'b1, 2'b01, 9, 12, 0, 1'b1);
        check("linear_0", 16'h0001);
        step(1'b1, 2'b01, 9, 12, 15, 1'b0);
        check("linear_15", 16'hFFFF);

        // Test modes and the one-edge switch delay.
        step(1'b1, 2'b10, 3, 12, 8, 1'b1);
        check("test_off", 16'h0000);
        step(1'b1, 2'b11, 3, 12, 8, 1'b0);
        check("test_on", 16'hFFFF);
        drive(1'b1, 2'b10, 3, 12, 8, 1'b0);
        #1;
        check("switch_before_edge", 16'hFFFF);
        @(posedge clk);
        #1;
        check("switch_after_edge", 16'h0000);

        // Mid-operation reset clears at that edge, then recovers.
        step(1'b1, 2'b11, 0, 0, 0, 1'b0);
        check("pre_mid_reset", 16'hFFFF);
        step(1'b0, 2'b11, 0, 0, 0, 1'b0);
        check("mid_reset", 16'h0000);
        step(1'b1, 2'b01, 0, 0, 3, 1'b0);
        check("post_mid_reset", 16'h000F);

        // Randomized cycles with occasional reset pulses.
        for (int n = 0; n < 10000; n++) begin
            r_o = ($urandom_range(0, 15) != 0);
            c_o = 2'($urandom_range(0, 3));
            mn  = $urandom_range(0, 15);
            mx  = $urandom_range(0, 15);
            v   = $urandom_range(0, 15);
            o_o = 1'($urandom_range(0, 1));
            step(r_o, c_o, mn, mx, v, o_o);
            check("random", model(r_o, c_o, mn, mx, v, o_o));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
